// File: rtl/fft_sdf_sequencer.sv
// fft_sdf_sequencer: control sequencer for a radix-2 SDF FFT pipeline.
// Owns the in/out handshakes, the global pipeline enable, the shared sample
// counter for twiddle/stage modes, fill-latency tracking and the zero-padded
// drain at end of stream.
// Optional build macro FFT_SEQ_BITREV_EN: when defined, out_index is the
// bit-reversed output count (true frequency bin); otherwise it is the
// natural arrival order.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for the first sample of a stream, in_ready=1
// RUN    | accepting the stream, one sample per enabled cycle
// PAD    | in_last came early: zero-fill up to the frame's index N-1
// FLUSH  | zero-fill for LAT enabled cycles to drain the datapath

module fft_sdf_sequencer #(
    parameter int N_LOG2   = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_last,
    output logic [N_LOG2-1:0] out_index,
    output logic              pipe_en,
    output logic              in_zero,
    output logic [N_LOG2:0]   counter,
    output logic [N_LOG2-1:0] stage_bf,
    output logic              tw_clr,
    output logic              err_frame
);

    localparam int N   = 1 << N_LOG2;
    localparam int LAT = N - 1 + PIPE_LAT;
    localparam int LW  = $clog2(LAT + 1);

    localparam logic [LW-1:0]     LAT_V      = LW'(LAT);
    localparam logic [LW-1:0]     FLUSH_LOAD = LW'(LAT - 1);
    localparam logic [N_LOG2-1:0] IDX_LAST   = N_LOG2'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAD   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_LOG2:0]     counter_q, counter_d;
    logic [LW-1:0]       lat_cnt_q, lat_cnt_d;
    logic [LW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [N_LOG2-1:0]   out_cnt_q, out_cnt_d;
    logic                primed_q, primed_d;
    logic                err_frame_q, err_frame_d;
    logic                tw_clr_q, tw_clr_d;

    logic src;
    logic accepting_state;
    logic accept;
    logic out_xfer;
    logic frame_end;
    logic flush_done;

    // Handshake and global enable; outputs only stall on a blocked output.
    always_comb begin
        accepting_state = (state_q == S_IDLE) || (state_q == S_RUN);
        src       = (accepting_state && in_valid) || (state_q == S_PAD) || (state_q == S_FLUSH);
        out_valid = primed_q && src;
        pipe_en   = src && (!out_valid || out_ready);
        in_ready  = accepting_state && (!primed_q || out_ready);
        accept    = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        frame_end = (counter_q[N_LOG2-1:0] == IDX_LAST);
    end

    // Next-state logic, error flag, flush down-counter and twiddle clear.
    always_comb begin
        state_d     = state_q;
        err_frame_d = err_frame_q;
        flush_cnt_d = flush_cnt_q;
        tw_clr_d    = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    state_d = S_RUN;
                    if (in_last) begin
                        if (frame_end) begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end else begin
                            state_d     = S_PAD;
                            err_frame_d = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                if (pipe_en && frame_end) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (pipe_en) begin
                    if (flush_cnt_q == '0) begin
                        state_d    = S_IDLE;
                        tw_clr_d   = 1'b1;
                        flush_done = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sample, fill-latency and output counters; all cleared when a drain completes.
    always_comb begin
        counter_d = counter_q;
        lat_cnt_d = lat_cnt_q;
        out_cnt_d = out_cnt_q;
        primed_d  = primed_q;
        if (flush_done) begin
            counter_d = '0;
            lat_cnt_d = '0;
            out_cnt_d = '0;
            primed_d  = 1'b0;
        end else begin
            if (pipe_en) begin
                counter_d = counter_q + 1'b1;
                if (lat_cnt_q != LAT_V) begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            if (out_xfer) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
            primed_d = primed_q || (lat_cnt_d == LAT_V);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            lat_cnt_q   <= '0;
            flush_cnt_q <= '0;
            out_cnt_q   <= '0;
            primed_q    <= 1'b0;
            err_frame_q <= 1'b0;
            tw_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            lat_cnt_q   <= lat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            out_cnt_q   <= out_cnt_d;
            primed_q    <= primed_d;
            err_frame_q <= err_frame_d;
            tw_clr_q    <= tw_clr_d;
        end
    end

    // Stage modes and output indexing derived from the counters.
    always_comb begin
        stage_bf = '0;
        for (int s = 0; s < N_LOG2; s++) begin
            stage_bf[s] = counter_q[N_LOG2-1-s];
        end
`ifdef FFT_SEQ_BITREV_EN
        out_index = '0;
        for (int b = 0; b < N_LOG2; b++) begin
            out_index[b] = out_cnt_q[N_LOG2-1-b];
        end
`else
        out_index = out_cnt_q;
`endif
    end

    assign out_last  = out_valid && (out_cnt_q == IDX_LAST);
    assign in_zero   = (state_q == S_PAD) || (state_q == S_FLUSH);
    assign counter   = counter_q;
    assign tw_clr    = tw_clr_q;
    assign err_frame = err_frame_q;

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Scoreboard bench for fft_sdf_sequencer (N=16, PIPE_LAT=2, LAT=17).
module tb_fft_sdf_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_last;
    logic [3:0] out_index;
    logic       pipe_en;
    logic       in_zero;
    logic [4:0] counter;
    logic [3:0] stage_bf;
    logic       tw_clr;
    logic       err_frame;

    fft_sdf_sequencer #(.N_LOG2(4), .PIPE_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_last(out_last), .out_index(out_index), .pipe_en(pipe_en),
        .in_zero(in_zero), .counter(counter), .stage_bf(stage_bf),
        .tw_clr(tw_clr), .err_frame(err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] brev_tbl [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                  4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    logic [4:0] sb [$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int out_seen = 0;
    int twc = 0;
    int zc = 0;
    int first_out_cyc = 0;
    int last_out_cyc = 0;
    bit arm_first = 0;
    int acc_idx = 0;
    int acc_cyc = 0;
    int stalls = 0;
    int base = 0;
    int prev_twc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_idx(input int k);
`ifdef FFT_SEQ_BITREV_EN
        return brev_tbl[k % 16];
`else
        return 4'(k % 16);
`endif
    endfunction

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        logic [4:0] e;
        if (tw_clr) twc++;
        if (in_zero && pipe_en) zc++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got index %0d, expected no output", out_index);
            end else begin
                e = sb.pop_front();
                chk("out_index", int'(out_index), int'(e[3:0]));
                chk("out_last", int'(out_last), int'(e[4]));
            end
            if (arm_first) begin
                first_out_cyc = cyc;
                arm_first = 0;
            end
            last_out_cyc = cyc;
            out_seen++;
        end
    end

    task automatic push_frames(input int nf);
        for (int k = 0; k < 16 * nf; k++) begin
            sb.push_back({(k % 16) == 15, exp_idx(k)});
        end
    endtask

    task automatic start_sc();
        base = out_seen;
        zc = 0;
        acc_idx = 0;
        stalls = 0;
        arm_first = 1;
        prev_twc = twc;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_pipe_en", int'(pipe_en), 0);
        chk("rst_in_zero", int'(in_zero), 0);
        chk("rst_counter", int'(counter), 0);
        chk("rst_stage_bf", int'(stage_bf), 0);
        chk("rst_tw_clr", int'(tw_clr), 0);
        chk("rst_err_frame", int'(err_frame), 0);
    endtask

    // Drive n samples back to back, in_last on the final one.
    task automatic send(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            @(negedge clk);
            t = 0;
            while (!in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) chk("accept_in_ready", int'(in_ready), 1);
            stalls += t;
            chk("counter_at_accept", int'(counter), acc_idx % 32);
            chk("stage_bf_at_accept", int'(stage_bf), int'(brev_tbl[acc_idx % 16]));
            if (acc_idx == 0) acc_cyc = cyc;
            acc_idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_outputs(input int k);
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (out_seen - base >= k) break;
        end
    endtask

    task automatic wait_done(input int nf);
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (twc > prev_twc) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("tw_clr_pulses", twc - prev_twc, 1);
        chk("output_count", out_seen - base, 16 * nf);
        chk("scoreboard_empty", sb.size(), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_in_zero", int'(in_zero), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single frame: latency, stage modes, out_last
        start_sc();
        push_frames(1);
        send(16);
        wait_done(1);
        chk("first_out_latency", first_out_cyc - acc_cyc, 17);
        chk("flush_zero_cycles", zc, 17);
        chk("err_after_good", int'(err_frame), 0);

        // two back-to-back frames
        start_sc();
        push_frames(2);
        send(32);
        wait_done(2);
        chk("b2b_in_ready_stalls", stalls, 0);
        chk("b2b_contiguous", last_out_cyc - first_out_cyc, 31);

        // output backpressure for 3 cycles
        start_sc();
        push_frames(1);
        send(16);
        wait_outputs(5);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_pipe_en", int'(pipe_en), 0);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_counter", int'(counter), 22);
            chk("stall_out_index", int'(out_index), int'(exp_idx(5)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(1);
        chk("stall_flush_enabled", zc, 17);

        // short frame: in_last on sample 5
        start_sc();
        push_frames(1);
        send(5);
        wait_done(1);
        chk("err_set", int'(err_frame), 1);
        chk("pad_flush_zero_cycles", zc, 28);

        // err_frame sticky across a good frame
        start_sc();
        push_frames(1);
        send(16);
        wait_done(1);
        chk("err_sticky", int'(err_frame), 1);

        // reset mid-FLUSH
        start_sc();
        push_frames(1);
        send(16);
        wait_outputs(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // frame after reset behaves like the first
        start_sc();
        push_frames(1);
        send(16);
        wait_done(1);
        chk("post_rst_latency", first_out_cyc - acc_cyc, 17);
        chk("post_rst_err", int'(err_frame), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
